// File: rtl/cla_arbiter.sv
// Round-robin arbiter that sequences add requests from NREQ clients onto one shared cla_32bit adder.
// Define CLA_ARB_SUB_EN to enable per-request subtraction (A + ~B + 1).
module cla_arbiter #(
   parameter int unsigned N    = 32,
   parameter int unsigned NREQ = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*N-1:0]       req_a,
   input  logic [NREQ*N-1:0]       req_b,
   input  logic [NREQ-1:0]         req_cin,
   input  logic [NREQ-1:0]         req_sub,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [N-1:0]            rsp_sum,
   output logic                    rsp_cout,
   output logic [$clog2(NREQ)-1:0] rsp_id
);
   localparam int unsigned IW = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t        state;
   logic [IW-1:0] ptr;
   logic [IW-1:0] id_q;
   logic [IW-1:0] grant_idx;
   logic          grant_any;
   logic [IW:0]   rr_sum;
   logic [IW-1:0] rr_idx;
   logic [N-1:0]  a_q, b_q;
   logic          cin_q;
   logic [N-1:0]  sel_a, sel_b, b_eff;
   logic          cin_eff;
   logic [N-1:0]  add_sum;
   logic          add_cout;

   // Cyclic first-valid search from ptr; descending scan so the lowest offset wins.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      rr_sum    = '0;
      rr_idx    = '0;
      for (int k = int'(NREQ) - 1; k >= 0; k--) begin
         rr_sum = {1'b0, ptr} + (IW+1)'(k);
         if (rr_sum >= (IW+1)'(NREQ)) rr_sum = rr_sum - (IW+1)'(NREQ);
         rr_idx = IW'(rr_sum);
         if (req_valid[rr_idx]) begin
            grant_any = 1'b1;
            grant_idx = rr_idx;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (rst_n && state == IDLE && grant_any) req_ready[grant_idx] = 1'b1;
   end

   assign sel_a = req_a[32'(grant_idx)*N +: N];
   assign sel_b = req_b[32'(grant_idx)*N +: N];

`ifdef CLA_ARB_SUB_EN
   assign b_eff   = req_sub[grant_idx] ? ~sel_b : sel_b;
   assign cin_eff = req_sub[grant_idx] ? 1'b1 : req_cin[grant_idx];
`else
   logic unused_sub;
   assign unused_sub = ^req_sub;
   assign b_eff      = sel_b;
   assign cin_eff    = req_cin[grant_idx];
`endif

   cla_32bit #(.N(N)) u_add (
      .a    (a_q),
      .b    (b_q),
      .cin  (cin_q),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         id_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         cin_q     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_sum   <= '0;
         rsp_cout  <= 1'b0;
         rsp_id    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  a_q   <= sel_a;
                  b_q   <= b_eff;
                  cin_q <= cin_eff;
                  id_q  <= grant_idx;
                  ptr   <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                  state <= EXEC;
               end
            end
            EXEC: begin
               rsp_sum   <= add_sum;
               rsp_cout  <= add_cout;
               rsp_id    <= id_q;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// Carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module cla_32bit #(
   parameter int unsigned N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);
   localparam int unsigned NG = (N + 3) / 4;
   localparam int unsigned W  = NG * 4;

   logic [W-1:0] ap, bp, g, p;
   logic [W:0]   c;
   logic [3:0]   gg, pg;
   logic         ci;

   assign ap = W'(a);
   assign bp = W'(b);
   assign g  = ap & bp;
   assign p  = ap ^ bp;

   always_comb begin
      c    = '0;
      c[0] = cin;
      gg   = '0;
      pg   = '0;
      ci   = 1'b0;
      for (int gi = 0; gi < int'(NG); gi++) begin
         gg = g[4*gi +: 4];
         pg = p[4*gi +: 4];
         ci = c[4*gi];
         c[4*gi+1] = gg[0] | (pg[0] & ci);
         c[4*gi+2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & ci);
         c[4*gi+3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
                   | (pg[2] & pg[1] & pg[0] & ci);
         c[4*gi+4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
                   | (pg[3] & pg[2] & pg[1] & gg[0]) | (pg[3] & pg[2] & pg[1] & pg[0] & ci);
      end
   end

   assign sum  = p[N-1:0] ^ c[N-1:0];
   assign cout = c[N];
endmodule

// File: doc/cla_arbiter.md
# cla_arbiter

Round-robin arbiter and sequencer that shares one `cla_32bit` adder instance among `NREQ` requesters. It accepts one add request at a time over per-requester valid/ready handshakes and registers the operands. It drives the shared adder, then holds the tagged result on a single valid/ready response port until it is consumed. It sits between the client blocks that need addition and the single carry-lookahead adder datapath.

## Interface
- `N`, 32, operand/sum width; passed to the internal `cla_32bit #(.N(N))`.
- `NREQ`, 4, number of requesters; legal range 2..16.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester grant; at most one bit set.
- `req_a`  in  NREQ*N  operand A; requester i occupies bits [i*N +: N].
- `req_b`  in  NREQ*N  operand B; same packing as `req_a`.
- `req_cin`  in  NREQ  carry-in per requester.
- `req_sub`  in  NREQ  subtract select per requester; used only with `CLA_ARB_SUB_EN`.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_sum`  out  N  sum.
- `rsp_cout`  out  1  carry-out.
- `rsp_id`  out  $clog2(NREQ)  index of the requester that owns the result.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE: if any `req_valid` is high, grant index g, the first valid index at or after `ptr`, searching cyclically.
  - `req_ready[g]`=1 combinationally in the same cycle.
  - On the clock edge, capture `a_q`, `b_q`, `cin_q`, `id_q`=g and move to EXEC.
  - `ptr` ← (g+1) mod NREQ.
  - If no request is valid, stay in IDLE.
- EXEC: the registered operands drive the adder.
  - On the edge, `rsp_sum`/`rsp_cout` ← adder outputs and `rsp_id` ← `id_q`.
  - `rsp_valid` ← 1 and the FSM moves to RESP.
- RESP: `rsp_*` are held stable while `rsp_ready`=0.
  - On `rsp_valid && rsp_ready`: `rsp_valid` ← 0 and the FSM returns to IDLE.
- `req_ready` is 0 in EXEC and RESP and whenever `rst_n`=0.
- Requests are not held by the arbiter. A requester keeps its operands stable while `req_valid` is high and `req_ready` is low; dropping valid before grant is legal.
- Arithmetic: `{rsp_cout, rsp_sum}` = A + B + cin, modulo 2^(N+1). Two's-complement interpretation is the consumer's concern.
- Reset values: `rsp_valid`=0, `rsp_sum`=0, `rsp_cout`=0, `rsp_id`=0, `req_ready`=0, `ptr`=0, FSM=IDLE.
- Reset mid-operation: an in-flight request in EXEC or RESP is discarded and no response is issued. The requester has already seen its handshake and must reissue.
- Simultaneous valids: exactly one grant per accepted transaction. Round-robin order guarantees each continuously requesting client is served within NREQ transactions.
- `ptr` wrap: after index NREQ-1 is granted, `ptr`=0.

## Timing
- Request accepted at edge T (`req_valid[g] && req_ready[g]`); `rsp_valid`=1 from T+2.
- With `rsp_ready` held at 1: response handshake at T+2, IDLE at T+3, next grant at T+3. Throughput is one transaction per 3 cycles.
- Each cycle of `rsp_ready`=0 in RESP adds one cycle; no other stalls.
- The adder path is purely combinational between `a_q/b_q/cin_q` and the `rsp_*` registers: one full cycle.

## Configuration
- `CLA_ARB_SUB_EN` defined: the adder sees B' and cin' instead of B and cin.
  - If `req_sub[g]`=1 at grant: B' = ~B and cin' = 1; `req_cin` is ignored.
  - In this mode `rsp_cout`=1 means no borrow (A ≥ B unsigned).
  - If `req_sub[g]`=0: B' = B and cin' = `req_cin`.
- Not defined: `req_sub` is unconnected internally and every request is A+B+cin.

## Test plan
- Single add: req0 issues A=5, B=10, cin=0 at T. Required: `rsp_sum`=15, `rsp_cout`=0, `rsp_id`=0, `rsp_valid` rising at T+2.
- Signed wrap: req2 issues A=30, B=0xFFFFFFF6 (−10), cin=0. Required: `rsp_sum`=20, `rsp_cout`=1, `rsp_id`=2. Also A=5, B=10, cin=1 → `rsp_sum`=16.
- Fairness: all four `req_valid` held high with distinct operands and `rsp_ready`=1. Required grant order 0,1,2,3,0; one-hot `req_ready`; grants every 3 cycles.
- Backpressure: `rsp_ready`=0 for 5 cycles after `rsp_valid`. Required: `rsp_sum`/`rsp_cout`/`rsp_id` stable; `req_ready` all 0; release yields exactly one handshake, then IDLE.
- Reset mid-flight: assert `rst_n`=0 during EXEC. Required: all outputs immediately 0; no response after release; the next grant goes to index 0.
- With `CLA_ARB_SUB_EN`, req1 issues sub A=5, B=10. Required: `rsp_sum`=0xFFFFFFFB, `rsp_cout`=0. Sub A=127, B=1 → `rsp_sum`=126, `rsp_cout`=1.
